// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial transmit controller.
//   state_t     : controller FSM states.
//   DW_MAX      : widest data word frame_build() supports.
//   frame_build : forms {start, bitrev(data), parity, stop}, right-aligned.
package serial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int unsigned DW_MAX = 32;

  // The caller zero-extends data to DW_MAX bits and keeps the low dw+3 bits of the result.
  // Bits above the frame come out as zero, so the start bit (0) lands at position dw+2 for free.
  // The data word is bit-reversed so that data[0] sits right after the start bit and goes
  // out first from the MSB-first shift register.
  function automatic logic [DW_MAX+2:0] frame_build(input logic [DW_MAX-1:0] data,
                                                    input int unsigned     dw,
                                                    input logic            parity_odd);
    logic [DW_MAX-1:0] rev;
    logic [DW_MAX-1:0] rem;
    rev = '0;
    rem = data;
    for (int unsigned i = 0; i < DW_MAX; i++) begin
      if (i < dw) begin
        rev = {rev[DW_MAX-2:0], rem[0]};
      end
      rem = rem >> 1;
    end
    return {1'b0, rev, (^data) ^ parity_odd, 1'b1};
  endfunction

endpackage

// File: rtl/serial_frame_ctrl.sv
// Transmit sequencer for an external N-bit MSB-first shift register (N = DW+3).
// Accepts a word on a valid/ready handshake, loads the framed word into the register and
// paces shifting at one bit per BAUD_DIV clocks by reloading the register onto itself.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   tx_valid, tx_data : host word offer (LSB transmitted first)
//   tx_ready          : word can be accepted (IDLE only)
//   busy              : frame in progress
//   tx_done           : one-cycle pulse after the last bit period
//   sr_load, sr_sin   : register load / serial input controls
//   sr_d              : register parallel input
//   sr_q              : register contents, fed back for hold cycles
module serial_frame_ctrl
  import serial_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned BAUD_DIV   = 4,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_valid,
  input  logic [DW-1:0]   tx_data,
  output logic            tx_ready,
  output logic            busy,
  output logic            tx_done,
  output logic            sr_load,
  output logic            sr_sin,
  output logic [DW+2:0]   sr_d,
  input  logic [DW+2:0]   sr_q
);

  localparam int unsigned N   = DW + 3;
  localparam int unsigned BCW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned NCW = $clog2(N + 1);

  localparam logic [BCW-1:0] BaudLast = BCW'(BAUD_DIV - 1);
  localparam logic [NCW-1:0] BitLast  = NCW'(N - 1);

  state_t         state_q, state_d;
  logic [BCW-1:0] baud_cnt_q, baud_cnt_d;
  logic [NCW-1:0] bit_cnt_q, bit_cnt_d;
  logic           tx_done_q, tx_done_d;
  logic [N-1:0]   frame;
  logic           accept;

  assign frame    = N'(frame_build(DW_MAX'(tx_data), DW, PARITY_ODD));
  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q == SEND);
  assign tx_done  = tx_done_q;
  // Ones are shifted in behind the frame, so the line idles high once the stop bit is out.
  assign sr_sin   = 1'b1;
  // Gating with reset keeps sr_load low while reset is held.
  assign accept   = tx_valid && tx_ready && reset;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_done_d  = 1'b0;
    sr_load    = 1'b0;
    sr_d       = frame;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sr_load    = 1'b1;
          state_d    = SEND;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      SEND: begin
        if (baud_cnt_q != BaudLast) begin
          // Hold cycle: reload the register with itself so the current bit stays on the line.
          sr_load    = 1'b1;
          sr_d       = sr_q;
          baud_cnt_d = baud_cnt_q + 1'b1;
        end else begin
          baud_cnt_d = '0;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitLast) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            tx_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_done_q  <= tx_done_d;
    end
  end

endmodule
